fan_mode_ctrl: RTL and testbench
================================

FAN_MODE_CTRL -- requirements
Module: fan_mode_ctrl

Interface
REQ-001 SHALL have parameter CLK_PER_100MS, default 10_000_000; clock cycles per 100 ms tick at 100 MHz.
REQ-002 SHALL have parameter SPINUP_TICKS, default 5; minimum 100 ms ticks in LOW before HIGH is entered.
REQ-003 SHALL have parameter LOW_THRESH, default 8'd20; battery level below which HIGH is disallowed.
REQ-004 SHALL have port clk, input, 1, the single clock for all logic.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port btn_power, input, 1, single-cycle power-toggle request.
REQ-007 SHALL have port btn_speed, input, 1, single-cycle LOW/HIGH toggle request.
REQ-008 SHALL have port sw0, input, 1, charger connected.
REQ-009 SHALL have port battery, input, 8, battery level 0..99 from the battery manager.
REQ-010 SHALL have port battery_empty, input, 1, battery level is 0.
REQ-011 SHALL have port state, output, 2, fan state: 00 OFF, 01 LOW, 10 HIGH; 11 is never driven.
REQ-012 SHALL have port timer_100ms, output, 1, one-cycle pulse every CLK_PER_100MS cycles.
REQ-013 SHALL have port timer_200ms, output, 1, one-cycle pulse coincident with every second timer_100ms.
REQ-014 SHALL have port spinup_busy, output, 1, high while a LOW-to-HIGH request is pending.

Function
REQ-015 Tick generator SHALL count 0..CLK_PER_100MS-1 and pulse timer_100ms for one cycle when the count wraps to 0; the first pulse is CLK_PER_100MS cycles after reset release.
REQ-016 A 1-bit phase SHALL toggle on each timer_100ms, and timer_200ms SHALL pulse on the timer_100ms where phase goes 1->0: the 2nd, 4th, ... tick.
REQ-017 The FSM SHALL have states OFF, LOW and HIGH, and state SHALL be driven from a registered FSM with no combinational path from the inputs.
REQ-018 OFF + btn_power -> LOW, only if !battery_empty || sw0; otherwise the request is ignored.
REQ-019 LOW/HIGH + btn_power -> OFF next cycle and SHALL clear any pending spin-up.
REQ-020 Spin-up counter SHALL clear on entry to LOW, increment on each timer_100ms while in LOW, and saturate at SPINUP_TICKS.
REQ-021 LOW + btn_speed with counter == SPINUP_TICKS and battery >= LOW_THRESH -> HIGH next cycle.
REQ-022 LOW + btn_speed with counter < SPINUP_TICKS SHALL set pending; spinup_busy=1; LOW->HIGH occurs on the cycle after counter reaches SPINUP_TICKS.
REQ-023 A second btn_speed while pending SHALL cancel pending and stay LOW.
REQ-024 Pending with battery < LOW_THRESH when spin-up completes -> pending cleared, stay LOW.
REQ-025 HIGH + btn_speed -> LOW next cycle, with the spin-up counter restarted from 0.
REQ-026 battery_empty && !sw0 in LOW or HIGH -> OFF next cycle, pending cleared.
REQ-027 Same-cycle priority SHALL be: forced-off (REQ-026) > btn_power > btn_speed > pending completion > auto-downshift.
REQ-028 The tick generator SHALL run continuously, independent of FSM state.

Reset
REQ-029 rst=1 on a clk edge SHALL set state=OFF, timer_100ms=0, timer_200ms=0, spinup_busy=0, prescaler=0, phase=0, spin-up counter=0, pending=0.
REQ-030 Reset asserted mid-spin-up or mid-HIGH SHALL give the REQ-029 values on the next cycle, with no residual pending.

Configuration
REQ-031 Macro FAN_AUTO_DOWNSHIFT_EN SHALL control auto-downshift.
REQ-032 FAN_AUTO_DOWNSHIFT_EN defined: HIGH with battery < LOW_THRESH and !sw0 -> LOW on the next timer_200ms, spin-up counter cleared.
REQ-033 FAN_AUTO_DOWNSHIFT_EN undefined: HIGH is left only via btn_speed, btn_power, forced-off or reset; REQ-024 still applies.

Structure
REQ-034 Package fan_pkg SHALL hold the state encodings FAN_OFF=2'b00, FAN_LOW=2'b01, FAN_HIGH=2'b10, the battery maximum 8'd99, and the default LOW_THRESH.
REQ-035 The prescaler and 200 ms phase SHALL be a sub-module fan_tick_gen, parameterised by CLK_PER_100MS; the FSM lives in fan_mode_ctrl.

Verification (CLK_PER_100MS=10, SPINUP_TICKS=5)
REQ-036 Release rst, idle 40 cycles -> timer_100ms at cycles 10/20/30/40; timer_200ms at 20/40 only.
REQ-037 battery=50, btn_power then btn_speed 1 cycle later -> state 01, spinup_busy=1; state 10 on the cycle after the 5th tick; spinup_busy=0.
REQ-038 battery=0, battery_empty=1, sw0=0, btn_power -> state stays 00; same with sw0=1 -> state 01.
REQ-039 HIGH with battery=50; battery_empty=1 and btn_speed in the same cycle, sw0=0 -> state 00 next cycle.
REQ-040 FAN_AUTO_DOWNSHIFT_EN defined, HIGH, battery=15, sw0=0 -> state 01 at the next timer_200ms; macro undefined -> stays 10.
REQ-041 rst pulsed while pending -> all outputs at REQ-029 values next cycle; a later btn_power gives LOW with spinup_busy=0.

Source files
------------

// File: rtl/fan_pkg.sv
// Shared definitions for the fan mode controller: state encodings,
// battery limits and a helper to clamp the battery reading.
package fan_pkg;

    typedef enum logic [1:0] {
        FAN_OFF  = 2'b00,
        FAN_LOW  = 2'b01,
        FAN_HIGH = 2'b10
    } fan_state_e;

    localparam logic [7:0] FAN_BATT_MAX       = 8'd99;
    localparam logic [7:0] FAN_LOW_THRESH_DEF = 8'd20;

    // Readings above the manager's documented range are treated as full.
    function automatic logic [7:0] batt_clamp(input logic [7:0] lvl);
        return (lvl > FAN_BATT_MAX) ? FAN_BATT_MAX : lvl;
    endfunction

endpackage

// File: rtl/fan_tick_gen.sv
// Free-running 100 ms prescaler with a 200 ms phase bit; both pulses are
// registered and run regardless of the fan state.
module fan_tick_gen #(
    parameter int CLK_PER_100MS = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick_100ms,
    output logic tick_200ms
);

    localparam int            PW   = (CLK_PER_100MS > 1) ? $clog2(CLK_PER_100MS) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_PER_100MS - 1);

    logic [PW-1:0] presc;
    logic          phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            presc      <= '0;
            phase      <= 1'b0;
            tick_100ms <= 1'b0;
            tick_200ms <= 1'b0;
        end else begin
            tick_100ms <= (presc == LAST);
            // The 200 ms pulse lands on the tick where phase falls 1->0.
            tick_200ms <= (presc == LAST) && phase;
            if (presc == LAST) begin
                presc <= '0;
                phase <= ~phase;
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

endmodule

// File: rtl/fan_mode_ctrl.sv
// Fan OFF/LOW/HIGH controller with spin-up delay before HIGH and battery gating.
// Optional macro FAN_AUTO_DOWNSHIFT_EN drops HIGH to LOW on a low battery.
module fan_mode_ctrl
    import fan_pkg::*;
#(
    parameter int         CLK_PER_100MS = 10_000_000,
    parameter int         SPINUP_TICKS  = 5,
    parameter logic [7:0] LOW_THRESH    = FAN_LOW_THRESH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_power,
    input  logic       btn_speed,
    input  logic       sw0,
    input  logic [7:0] battery,
    input  logic       battery_empty,
    output logic [1:0] state,
    output logic       timer_100ms,
    output logic       timer_200ms,
    output logic       spinup_busy
);

    localparam int            CW       = $clog2(SPINUP_TICKS + 1);
    localparam logic [CW-1:0] SPIN_MAX = CW'(SPINUP_TICKS);

    fan_state_e    state_q, state_d;
    logic [CW-1:0] spin_cnt_q, spin_cnt_d;
    logic          pending_q, pending_d;
    logic [7:0]    batt;
    logic          forced_off, batt_ok, spun_up;

    fan_tick_gen #(
        .CLK_PER_100MS(CLK_PER_100MS)
    ) u_tick_gen (
        .clk       (clk),
        .rst       (rst),
        .tick_100ms(timer_100ms),
        .tick_200ms(timer_200ms)
    );

    assign batt       = batt_clamp(battery);
    assign forced_off = battery_empty && !sw0;
    assign batt_ok    = (batt >= LOW_THRESH);
    assign spun_up    = (spin_cnt_q == SPIN_MAX);

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        spin_cnt_d = spin_cnt_q;
        if (state_q == FAN_LOW && timer_100ms && !spun_up)
            spin_cnt_d = spin_cnt_q + CW'(1);

        // Priority: forced-off, power, speed, pending completion, downshift.
        case (state_q)
            FAN_OFF: begin
                if (btn_power && !forced_off) begin
                    state_d    = FAN_LOW;
                    spin_cnt_d = '0;
                end
            end
            FAN_LOW: begin
                if (forced_off || btn_power) begin
                    state_d   = FAN_OFF;
                    pending_d = 1'b0;
                end else if (btn_speed) begin
                    if (pending_q)
                        pending_d = 1'b0;
                    else if (!spun_up)
                        pending_d = 1'b1;
                    else if (batt_ok)
                        state_d = FAN_HIGH;
                end else if (pending_q && spun_up) begin
                    pending_d = 1'b0;
                    if (batt_ok)
                        state_d = FAN_HIGH;
                end
            end
            FAN_HIGH: begin
                if (forced_off || btn_power) begin
                    state_d = FAN_OFF;
                end else if (btn_speed) begin
                    state_d    = FAN_LOW;
                    spin_cnt_d = '0;
                end
`ifdef FAN_AUTO_DOWNSHIFT_EN
                else if (timer_200ms && !batt_ok && !sw0) begin
                    state_d    = FAN_LOW;
                    spin_cnt_d = '0;
                end
`endif
            end
            default: begin
                state_d    = FAN_OFF;
                pending_d  = 1'b0;
                spin_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FAN_OFF;
            spin_cnt_q <= '0;
            pending_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            spin_cnt_q <= spin_cnt_d;
            pending_q  <= pending_d;
        end
    end

    assign state       = state_q;
    assign spinup_busy = pending_q;

endmodule

// File: tb/tb_fan_mode_ctrl.sv
// Scoreboard bench for fan_mode_ctrl with CLK_PER_100MS=10, SPINUP_TICKS=5.
module tb_fan_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_power = 1'b0;
    logic       btn_speed = 1'b0;
    logic       sw0 = 1'b0;
    logic [7:0] battery = 8'd50;
    logic       battery_empty = 1'b0;
    logic [1:0] state;
    logic       timer_100ms, timer_200ms, spinup_busy;

    localparam logic [1:0] S_OFF  = 2'b00;
    localparam logic [1:0] S_LOW  = 2'b01;
    localparam logic [1:0] S_HIGH = 2'b10;

    always #5 clk = ~clk;

    fan_mode_ctrl #(
        .CLK_PER_100MS(10),
        .SPINUP_TICKS (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_power    (btn_power),
        .btn_speed    (btn_speed),
        .sw0          (sw0),
        .battery      (battery),
        .battery_empty(battery_empty),
        .state        (state),
        .timer_100ms  (timer_100ms),
        .timer_200ms  (timer_200ms),
        .spinup_busy  (spinup_busy)
    );

    typedef struct {
        string      name;
        logic [4:0] val;
        logic [4:0] mask;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   k = 0;

    function automatic logic [4:0] obs();
        return {state, spinup_busy, timer_100ms, timer_200ms};
    endfunction

    // Expected {timer_100ms, timer_200ms} c cycles after reset release.
    function automatic logic [1:0] tk(input int c);
        return {(c > 0) && (c % 10 == 0), (c > 0) && (c % 20 == 0)};
    endfunction

    function automatic exp_t mk(input string n, input logic [1:0] st, input logic b,
                                input logic [1:0] t, input logic [4:0] m);
        exp_t x;
        x.name = n;
        x.val  = {st, b, t};
        x.mask = m;
        return x;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        btn_power = 1'b0;
        btn_speed = 1'b0;
        step();
        rst = 1'b0;
        k = 0;
    endtask

    task automatic test_reset(input string n);
        exp_t e;
        rst = 1'b1;
        btn_power = 1'b1;
        btn_speed = 1'b1;
        sb.push_back(mk(n, S_OFF, 1'b0, 2'b00, 5'b11111));
        step();
        rst = 1'b0;
        btn_power = 1'b0;
        btn_speed = 1'b0;
        k = 0;
        e = sb.pop_front();
        checks++;
        if (obs() !== e.val) begin
            errors++;
            $display("FAIL %s: got %b want %b", e.name, obs(), e.val);
        end
    endtask

    task automatic test_ticks();
        exp_t e;
        do_reset();
        for (int c = 1; c <= 40; c++) begin
            sb.push_back(mk("ticks", S_OFF, 1'b0, tk(c), 5'b11111));
            step();
            e = sb.pop_front();
            checks++;
            if ((obs() & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("FAIL %s c=%0d: got %b want %b", e.name, c, obs(), e.val);
            end
        end
    endtask

    task automatic test_spinup();
        exp_t e;
        do_reset();
        battery = 8'd50; battery_empty = 1'b0; sw0 = 1'b0;
        for (int c = 1; c <= 55; c++) begin
            btn_power = (c == 1);
            btn_speed = (c == 2) || (c >= 53);
            if (c == 1)       sb.push_back(mk("spinup_enter", S_LOW, 1'b0, tk(c), 5'b11111));
            else if (c <= 50) sb.push_back(mk("spinup_wait", S_LOW, 1'b1, tk(c), 5'b11111));
            else if (c == 51) sb.push_back(mk("spinup_edge", S_LOW, 1'b1, tk(c), 5'b00011));
            else if (c == 52) sb.push_back(mk("spinup_high", S_HIGH, 1'b0, tk(c), 5'b11111));
            else if (c == 53) sb.push_back(mk("high_to_low", S_LOW, 1'b0, tk(c), 5'b11111));
            else if (c == 54) sb.push_back(mk("repend", S_LOW, 1'b1, tk(c), 5'b11111));
            else              sb.push_back(mk("cancel", S_LOW, 1'b0, tk(c), 5'b11111));
            step();
            btn_power = 1'b0;
            btn_speed = 1'b0;
            e = sb.pop_front();
            checks++;
            if ((obs() & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("FAIL %s c=%0d: got %b want %b", e.name, c, obs(), e.val);
            end
        end
    endtask

    task automatic test_gate();
        exp_t e;
        logic [1:0] st;
        do_reset();
        battery = 8'd0; battery_empty = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            sw0       = (c == 2) || (c == 4) || (c == 5);
            btn_power = (c != 3);
            st = (c == 2 || c == 4) ? S_LOW : S_OFF;
            sb.push_back(mk("power_gate", st, 1'b0, tk(c), 5'b11111));
            step();
            btn_power = 1'b0;
            e = sb.pop_front();
            checks++;
            if ((obs() & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("FAIL %s c=%0d: got %b want %b", e.name, c, obs(), e.val);
            end
        end
        sw0 = 1'b0; battery = 8'd50; battery_empty = 1'b0;
    endtask

    task automatic test_high_entry();
        exp_t e;
        logic [1:0] st;
        do_reset();
        sw0 = 1'b0; battery_empty = 1'b0;
        for (int c = 1; c <= 55; c++) begin
            battery       = (c == 52) ? 8'd15 : 8'd50;
            battery_empty = (c >= 54);
            btn_power     = (c == 1) || (c == 55);
            btn_speed     = (c >= 52) && (c <= 54);
            st = (c <= 52) ? S_LOW : (c == 53) ? S_HIGH : S_OFF;
            sb.push_back(mk("high_entry", st, 1'b0, tk(c), 5'b11111));
            step();
            btn_power = 1'b0;
            btn_speed = 1'b0;
            e = sb.pop_front();
            checks++;
            if ((obs() & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("FAIL %s c=%0d: got %b want %b", e.name, c, obs(), e.val);
            end
        end
        battery_empty = 1'b0; battery = 8'd50;
    endtask

    task automatic test_pending_low_batt();
        exp_t e;
        do_reset();
        battery = 8'd50; battery_empty = 1'b0; sw0 = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            battery   = (c >= 45) ? 8'd15 : 8'd50;
            btn_power = (c == 1);
            btn_speed = (c == 2);
            if (c == 1)       sb.push_back(mk("plb_enter", S_LOW, 1'b0, tk(c), 5'b11111));
            else if (c <= 50) sb.push_back(mk("plb_wait", S_LOW, 1'b1, tk(c), 5'b11111));
            else if (c == 51) sb.push_back(mk("plb_edge", S_LOW, 1'b1, tk(c), 5'b00011));
            else              sb.push_back(mk("plb_cleared", S_LOW, 1'b0, tk(c), 5'b11111));
            step();
            btn_power = 1'b0;
            btn_speed = 1'b0;
            e = sb.pop_front();
            checks++;
            if ((obs() & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("FAIL %s c=%0d: got %b want %b", e.name, c, obs(), e.val);
            end
        end
        battery = 8'd50;
    endtask

    task automatic test_autodown();
        exp_t e;
        logic [1:0] st;
        do_reset();
        battery_empty = 1'b0; sw0 = 1'b0;
        for (int c = 1; c <= 85; c++) begin
            battery   = (c >= 63) ? 8'd15 : 8'd50;
            btn_power = (c == 1);
            btn_speed = (c == 62);
            if (c <= 61)      st = S_LOW;
            else if (c <= 80) st = S_HIGH;
            else begin
`ifdef FAN_AUTO_DOWNSHIFT_EN
                st = S_LOW;
`else
                st = S_HIGH;
`endif
            end
            sb.push_back(mk("autodown", st, 1'b0, tk(c), 5'b11111));
            step();
            btn_power = 1'b0;
            btn_speed = 1'b0;
            e = sb.pop_front();
            checks++;
            if ((obs() & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("FAIL %s c=%0d: got %b want %b", e.name, c, obs(), e.val);
            end
        end
        battery = 8'd50;
    endtask

    task automatic test_reset_pending();
        exp_t e;
        do_reset();
        battery = 8'd50; battery_empty = 1'b0; sw0 = 1'b0;
        for (int c = 1; c <= 42; c++) begin
            rst       = (c == 20);
            btn_power = (c == 1) || (c == 21);
            btn_speed = (c == 2);
            if (c == 1)       sb.push_back(mk("rp_enter", S_LOW, 1'b0, tk(c), 5'b11111));
            else if (c <= 19) sb.push_back(mk("rp_pending", S_LOW, 1'b1, tk(c), 5'b11111));
            else if (c == 20) sb.push_back(mk("rp_reset", S_OFF, 1'b0, 2'b00, 5'b11111));
            else              sb.push_back(mk("rp_after", S_LOW, 1'b0, tk(c), 5'b11111));
            step();
            rst = 1'b0;
            btn_power = 1'b0;
            btn_speed = 1'b0;
            e = sb.pop_front();
            checks++;
            if ((obs() & e.mask) !== (e.val & e.mask)) begin
                errors++;
                $display("FAIL %s c=%0d: got %b want %b", e.name, c, obs(), e.val);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        test_reset("reset_init");
        test_ticks();
        test_spinup();
        test_gate();
        test_high_entry();
        test_pending_low_batt();
        test_autodown();
        test_reset("reset_mid_run");
        test_reset_pending();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
